// File: rtl/gpio_debounce_pkg.sv
// gpio_debounce_pkg
//   Shared definitions for the GPIO input conditioner:
//     - chan_state_e : per-channel debounce FSM state encoding
//     - DEF_*        : default timing constants (1 ms tick at 12 MHz)
//     - clog2        : ceiling log2 for counter sizing
//     - bits_for     : clog2 clamped to a minimum of one bit
package gpio_debounce_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } chan_state_e;

    localparam int unsigned DEF_WIDTH        = 2;
    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_PRESCALE     = 12000;
    localparam int unsigned DEF_STABLE_TICKS = 10;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int unsigned bits_for(input int unsigned value);
        int unsigned r;
        r = clog2(value);
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan
//   One input channel: synchroniser, debounce FSM with tick counter,
//   debounced level, single-cycle edge pulses and a sticky event flag.
//   Ports:
//     clk        : system clock
//     reset      : synchronous, active-high reset
//     tick       : shared prescaler strobe
//     in_raw     : asynchronous pin
//     event_clr  : clears event_flag (set wins on collision)
//     level      : debounced level
//     rise, fall : one-cycle pulses aligned with the level change
//     event_flag : sticky, set the cycle after rise or fall
module debounce_chan
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic        INIT_LEVEL   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic in_raw,
    input  logic event_clr,
    output logic level,
    output logic rise,
    output logic fall,
    output logic event_flag
);

    localparam int unsigned       CNT_W    = bits_for(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    chan_state_e            state;
    logic [CNT_W-1:0]       cnt;

    always_comb sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= {SYNC_STAGES{INIT_LEVEL}};
            state      <= STABLE;
            cnt        <= '0;
            level      <= INIT_LEVEL;
            rise       <= 1'b0;
            fall       <= 1'b0;
            event_flag <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw};
            rise   <= 1'b0;
            fall   <= 1'b0;

            // A pulse registered last cycle sets the flag; it beats a clear.
            if (rise || fall)
                event_flag <= 1'b1;
            else if (event_clr)
                event_flag <= 1'b0;

            case (state)
                STABLE: begin
                    if (sync != level) begin
                        state <= PENDING;
                        cnt   <= tick ? CNT_W'(1) : '0;
                    end else begin
                        cnt <= '0;
                    end
                end
                PENDING: begin
                    if (sync == level) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (tick) begin
                        // >= rather than == keeps STABLE_TICKS=1 from wrapping.
                        if (cnt >= CNT_LAST) begin
                            level <= sync;
                            rise  <= sync;
                            fall  <= ~sync;
                            state <= STABLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gpio_debounce.sv
// gpio_debounce
//   Multi-channel push-button conditioner feeding the SoC GPIO inputs.
//   A shared prescaler produces the debounce tick; each channel is an
//   independent debounce_chan instance.
//   Ports:
//     clk        : system clock
//     reset      : synchronous, active-high reset
//     in_raw     : [WIDTH] asynchronous pins
//     level      : [WIDTH] debounced levels
//     rise, fall : [WIDTH] one-cycle pulses on accepted changes
//     event_flag : [WIDTH] sticky change flags
//     event_clr  : [WIDTH] per-channel flag clear
//     tick       : prescaler strobe
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned       WIDTH        = DEF_WIDTH,
    parameter int unsigned       SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned       PRESCALE     = DEF_PRESCALE,
    parameter int unsigned       STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic [WIDTH-1:0]  INIT_LEVEL   = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] event_flag,
    input  logic [WIDTH-1:0] event_clr,
    output logic             tick
);

    localparam int unsigned    PW     = bits_for(PRESCALE);
    localparam logic [PW-1:0]  P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    always_ff @(posedge clk) begin
        if (reset)
            pcnt <= '0;
        else if (pcnt == P_LAST)
            pcnt <= '0;
        else
            pcnt <= pcnt + 1'b1;
    end

    always_comb tick = (pcnt == P_LAST);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .INIT_LEVEL   (INIT_LEVEL[i])
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .in_raw     (in_raw[i]),
            .event_clr  (event_clr[i]),
            .level      (level[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .event_flag (event_flag[i])
        );
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce
//   Directed bench for gpio_debounce with PRESCALE=4, STABLE_TICKS=3,
//   SYNC_STAGES=2, WIDTH=2. A run-length model predicts every output
//   each cycle; literal checks pin latency, pulse widths and flag rules.
module tb_gpio_debounce;

    localparam int W  = 2;
    localparam int SS = 2;
    localparam int P  = 4;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_raw;
    logic [1:0] event_clr;
    logic [1:0] level, rise, fall, event_flag;
    logic       tick;

    always #5 clk = ~clk;

    gpio_debounce #(
        .WIDTH        (W),
        .SYNC_STAGES  (SS),
        .PRESCALE     (P),
        .STABLE_TICKS (ST),
        .INIT_LEVEL   (2'b11)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_raw     (in_raw),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .event_flag (event_flag),
        .event_clr  (event_clr),
        .tick       (tick)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a change is accepted on the ST-th tick seen during an unbroken
    // run of sync != level (tick on the run's first cycle counts, but the
    // run's first cycle itself never accepts).
    logic [1:0] pipe [SS];
    logic [1:0] lvl_m, rise_m, fall_m, ev_m;
    int         run_len   [2];
    int         run_ticks [2];
    int         cyc_m;
    logic       valid = 1'b0;

    task automatic model_step();
        logic [1:0] s;
        logic       tk;
        if (reset) begin
            for (int k = 0; k < SS; k++) pipe[k] = 2'b11;
            lvl_m  = 2'b11;
            rise_m = 2'b00;
            fall_m = 2'b00;
            ev_m   = 2'b00;
            for (int i = 0; i < W; i++) begin
                run_len[i]   = 0;
                run_ticks[i] = 0;
            end
            cyc_m = 0;
        end else begin
            s  = pipe[SS-1];
            tk = (cyc_m % P) == P - 1;
            for (int i = 0; i < W; i++) begin
                ev_m[i]   = (rise_m[i] | fall_m[i]) ? 1'b1 : (event_clr[i] ? 1'b0 : ev_m[i]);
                rise_m[i] = 1'b0;
                fall_m[i] = 1'b0;
                if (s[i] == lvl_m[i]) begin
                    run_len[i]   = 0;
                    run_ticks[i] = 0;
                end else begin
                    run_len[i] = run_len[i] + 1;
                    if (tk) run_ticks[i] = run_ticks[i] + 1;
                    if (run_len[i] > 1 && run_ticks[i] >= ST) begin
                        lvl_m[i]     = s[i];
                        rise_m[i]    = s[i];
                        fall_m[i]    = ~s[i];
                        run_len[i]   = 0;
                        run_ticks[i] = 0;
                    end
                end
            end
            for (int k = SS - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = in_raw;
            cyc_m = cyc_m + 1;
        end
        valid = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    int rc [2];
    int fc [2];
    initial begin
        rc[0] = 0; rc[1] = 0; fc[0] = 0; fc[1] = 0;
    end

    initial forever begin
        @(negedge clk);
        if (valid) begin
            check("outputs{level,rise,fall,event,tick}",
                  32'({level, rise, fall, event_flag, tick}),
                  32'({lvl_m, rise_m, fall_m, ev_m, ((cyc_m % P) == P - 1)}));
            for (int i = 0; i < W; i++) begin
                rc[i] = rc[i] + int'(rise[i]);
                fc[i] = fc[i] + int'(fall[i]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at a negedge once a selected pulse is seen or the budget expires.
    task automatic wait_pulse(input logic use_rise, input logic [1:0] mask,
                              input int budget, output int edges, output logic [1:0] seen);
        edges = 0;
        seen  = 2'b00;
        while (edges < budget) begin
            @(posedge clk);
            edges = edges + 1;
            @(negedge clk);
            seen = use_rise ? rise : fall;
            if ((seen & mask) != 2'b00) break;
        end
        if ((seen & mask) == 2'b00)
            check("pulse_timeout", 32'(edges), 32'(budget + 1));
    endtask

    int         edges;
    logic [1:0] seen;
    int         r0, r1, f0, f1;

    initial begin
        reset     = 1'b1;
        in_raw    = 2'b11;
        event_clr = 2'b00;

        // 1. Reset values
        wait_cycles(5);
        check("reset_level", 32'(level), 32'h3);
        check("reset_rise",  32'(rise), 32'h0);
        check("reset_fall",  32'(fall), 32'h0);
        check("reset_event", 32'(event_flag), 32'h0);
        check("reset_tick",  32'(tick), 32'h0);
        reset = 1'b0;
        wait_cycles(3);

        // 1b. Reset while ch0 is pending: no pulse
        f0 = fc[0];
        in_raw[0] = 1'b0;
        wait_cycles(8);
        reset  = 1'b1;
        in_raw = 2'b11;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(20);
        check("midreset_level", 32'(level), 32'h3);
        check("midreset_nofall", 32'(fc[0] - f0), 32'd0);

        // 2. Clean press on ch0
        in_raw[0] = 1'b0;
        wait_pulse(1'b0, 2'b01, 30, edges, seen);
        check("press_latency_in_range", 32'((edges >= 11) && (edges <= 14)), 32'd1);
        check("press_fall_seen", 32'(seen), 32'h1);
        @(negedge clk);
        check("press_fall_one_cycle", 32'(fall[0]), 32'd0);
        check("press_event_next", 32'(event_flag[0]), 32'd1);
        check("press_level", 32'(level), 32'h2);

        // 3. Bounce rejection
        wait_cycles(1);
        in_raw[0] = 1'b1;
        wait_cycles(20);
        f0 = fc[0];
        r0 = rc[0];
        for (int k = 0; k < 10; k++) begin
            in_raw[0] = 1'b0;
            wait_cycles(3);
            in_raw[0] = 1'b1;
            wait_cycles(3);
        end
        check("bounce_no_pulse", 32'((fc[0] - f0) + (rc[0] - r0)), 32'd0);
        check("bounce_level_held", 32'(level[0]), 32'd1);
        in_raw[0] = 1'b0;
        wait_cycles(20);
        check("bounce_settle_one_fall", 32'(fc[0] - f0), 32'd1);
        check("bounce_settle_level", 32'(level[0]), 32'd0);
        in_raw[0] = 1'b1;
        wait_cycles(20);

        // 4. One-cycle glitch on ch1
        r1 = rc[1];
        f1 = fc[1];
        in_raw[1] = 1'b0;
        wait_cycles(1);
        in_raw[1] = 1'b1;
        wait_cycles(20);
        check("glitch_level", 32'(level[1]), 32'd1);
        check("glitch_no_pulse", 32'((rc[1] - r1) + (fc[1] - f1)), 32'd0);

        // 5. Simultaneous press and release
        in_raw = 2'b00;
        wait_pulse(1'b0, 2'b11, 30, edges, seen);
        check("simul_fall", 32'(seen), 32'h3);
        wait_cycles(3);
        r0 = rc[0];
        r1 = rc[1];
        in_raw = 2'b11;
        wait_pulse(1'b1, 2'b11, 30, edges, seen);
        check("simul_rise", 32'(seen), 32'h3);
        wait_cycles(20);
        check("simul_rise_once", 32'({8'(rc[0] - r0), 8'(rc[1] - r1)}), 32'h0101);

        // 6. Clear colliding with set, then clear
        event_clr = 2'b11;
        wait_cycles(1);
        event_clr = 2'b00;
        wait_cycles(1);
        check("events_cleared", 32'(event_flag), 32'h0);
        in_raw[0] = 1'b0;
        wait_pulse(1'b0, 2'b01, 30, edges, seen);
        event_clr[0] = 1'b1;
        @(negedge clk);
        check("clr_collision_set_wins", 32'(event_flag[0]), 32'd1);
        @(negedge clk);
        check("clr_next_cycle", 32'(event_flag[0]), 32'd0);
        event_clr = 2'b00;
        wait_cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
